// File: rtl/nl2_dbank_wr_store_fwd_pkg.sv
// Shared types for the DBANK write store-and-forward buffer.
// AW payload layout and output FSM state encoding.
package nl2_dbank_wr_store_fwd_pkg;

    localparam int unsigned AW_ID_W   = 1;
    localparam int unsigned AW_ADDR_W = 20;
    localparam int unsigned AW_LEN_W  = 4;

    typedef struct packed {
        logic [AW_ID_W-1:0]   id;
        logic [AW_ADDR_W-1:0] addr;
        logic [2:0]           size;
        logic [AW_LEN_W-1:0]  len;
        logic [1:0]           burst;
        logic                 lock;
        logic [2:0]           prot;
        logic [3:0]           cache;
    } aw_t;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } wr_state_e;

endpackage

// File: rtl/nl2_dbank_wr_store_fwd_if.sv
// AXI4 AW/W write-channel bundle.
// The master side drives valid and payload; the slave side drives ready.
interface nl2_dbank_wr_store_fwd_if #(
    parameter int unsigned ID_W   = 1,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LEN_W  = 4
);
    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic [LEN_W-1:0]  awlen;
    logic [1:0]        awburst;
    logic              awlock;
    logic [2:0]        awprot;
    logic [3:0]        awcache;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    modport master (
        output awvalid, awid, awaddr, awsize, awlen,
        output awburst, awlock, awprot, awcache,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready
    );

    modport slave (
        input  awvalid, awid, awaddr, awsize, awlen,
        input  awburst, awlock, awprot, awcache,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready
    );

endinterface

// File: rtl/nl2_dbank_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// clr empties the FIFO on the next clock edge.
module nl2_dbank_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= adv(wr_ptr);
            if (do_pop)  rd_ptr <= adv(rd_ptr);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/nl2_dbank_wr_store_fwd.sv
// Store-and-forward AW/W buffer in front of the DBANK write channels.
// A command is released only once its whole W burst is held locally.
module nl2_dbank_wr_store_fwd
    import nl2_dbank_wr_store_fwd_pkg::*;
#(
    parameter int unsigned WR_ID_XSIZE   = 1,
    parameter int unsigned CMD_ADDR_SIZE = 20,
    parameter int unsigned DATA_SIZE     = 128,
    parameter int unsigned LEN_W         = 4,
    parameter int unsigned W_DEPTH       = 16,
    parameter int unsigned AW_DEPTH      = 4
) (
    input  logic                            dbnk_clk,
    input  logic                            rst_a,
    nl2_dbank_wr_store_fwd_if.slave         s,
    nl2_dbank_wr_store_fwd_if.master        m,
    output logic                            wbuf_idle
);
    localparam int unsigned STRB_W = DATA_SIZE / 8;
    localparam int unsigned W_W    = DATA_SIZE + STRB_W + 1;
    localparam int unsigned CNT_W  = $clog2(W_DEPTH + 1);

    if (W_DEPTH < (2 ** LEN_W)) begin : g_bad_w_depth
        $error("W_DEPTH must hold a maximum-length burst");
    end
    if (AW_DEPTH < 2) begin : g_bad_aw_depth
        $error("AW_DEPTH must be at least 2");
    end
    if (WR_ID_XSIZE != AW_ID_W || CMD_ADDR_SIZE != AW_ADDR_W
        || LEN_W != AW_LEN_W) begin : g_bad_aw_t
        $error("AW field widths must match aw_t");
    end

    aw_t             aw_in;
    aw_t             aw_head;
    logic            aw_full, aw_empty, aw_push, aw_pop;
    logic [W_W-1:0]  w_in;
    logic [W_W-1:0]  w_head;
    logic            w_full, w_empty, w_push, w_pop;
    logic            head_last;
    logic            aw_go, w_go;
    logic            cnt_inc, cnt_dec;
    logic [CNT_W-1:0] cmpl_cnt;
    wr_state_e       state, state_nxt;

    // Readies come only from registered FIFO flags, never from m_*ready.
    assign s.awready = !aw_full && !rst_a;
    assign s.wready  = !w_full && !rst_a;
    assign aw_push   = s.awvalid && s.awready;
    assign w_push    = s.wvalid && s.wready;

    assign aw_in = '{id: s.awid, addr: s.awaddr, size: s.awsize,
                     len: s.awlen, burst: s.awburst, lock: s.awlock,
                     prot: s.awprot, cache: s.awcache};
    assign w_in      = {s.wdata, s.wstrb, s.wlast};
    assign head_last = w_head[0];

    nl2_dbank_sync_fifo #(
        .WIDTH ($bits(aw_t)),
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk   (dbnk_clk),
        .clr   (rst_a),
        .push  (aw_push),
        .din   (aw_in),
        .pop   (aw_pop),
        .dout  (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    nl2_dbank_sync_fifo #(
        .WIDTH (W_W),
        .DEPTH (W_DEPTH)
    ) u_w_fifo (
        .clk   (dbnk_clk),
        .clr   (rst_a),
        .push  (w_push),
        .din   (w_in),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge dbnk_clk) begin
        if (rst_a) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        aw_go     = 1'b0;
        w_go      = 1'b0;
        aw_pop    = 1'b0;
        w_pop     = 1'b0;
        if (!rst_a) begin
            unique case (state)
                IDLE: begin
                    aw_go = !aw_empty && (cmpl_cnt != '0);
                    if (aw_go && m.awready) begin
                        aw_pop    = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    w_go = 1'b1;
                    if (m.wready) begin
                        w_pop = 1'b1;
                        if (head_last) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Number of complete bursts sitting in the W FIFO.
    assign cnt_inc = w_push && s.wlast;
    assign cnt_dec = w_pop && head_last;

    always_ff @(posedge dbnk_clk) begin
        if (rst_a) begin
            cmpl_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            cmpl_cnt <= cmpl_cnt + CNT_W'(1);
        end else if (!cnt_inc && cnt_dec) begin
            cmpl_cnt <= cmpl_cnt - CNT_W'(1);
        end
    end

    assign m.awvalid = aw_go;
    assign m.awid    = aw_go ? aw_head.id    : '0;
    assign m.awaddr  = aw_go ? aw_head.addr  : '0;
    assign m.awsize  = aw_go ? aw_head.size  : '0;
    assign m.awlen   = aw_go ? aw_head.len   : '0;
    assign m.awburst = aw_go ? aw_head.burst : '0;
    assign m.awlock  = aw_go && aw_head.lock;
    assign m.awprot  = aw_go ? aw_head.prot  : '0;
    assign m.awcache = aw_go ? aw_head.cache : '0;

    assign m.wvalid = w_go;
    assign m.wdata  = w_go ? w_head[W_W-1 -: DATA_SIZE] : '0;
    assign m.wstrb  = w_go ? w_head[STRB_W:1] : '0;
    assign m.wlast  = w_go && head_last;

    assign wbuf_idle = !rst_a && aw_empty && w_empty && (state == IDLE);

endmodule

// File: doc/nl2_dbank_wr_store_fwd.md
# nl2_dbank_wr_store_fwd

Store-and-forward write-burst buffer sitting directly upstream of the DBANK top layer write channels (AW/W). It accepts AXI4 write commands and write data from the cluster interconnect and buffers each burst completely. A command is released to the DBANK only after its entire W burst is held locally, so a slow or stalled bank never back-pressures a partially delivered burst into the interconnect. The read, B and R channels bypass this block.

## Interface
Parameters:
- WR_ID_XSIZE, 1, AW ID width
- CMD_ADDR_SIZE, 20, bank byte-address width
- DATA_SIZE, 128, W data width; strobe width is DATA_SIZE/8
- LEN_W, 4, awlen width; max burst length is 2^LEN_W beats
- W_DEPTH, 16, W FIFO entries; must be ≥ 2^LEN_W (elaboration assertion)
- AW_DEPTH, 4, AW FIFO entries; ≥ 2

Ports:
- dbnk_clk  in  1  clock
- rst_a  in  1  reset; synchronous, active-high
- s_awvalid/s_awready  in/out  1  upstream AW handshake
- s_awid, s_awaddr, s_awsize, s_awlen, s_awburst, s_awlock, s_awprot, s_awcache  in  WR_ID_XSIZE/CMD_ADDR_SIZE/3/LEN_W/2/1/3/4  AW fields
- s_wvalid/s_wready  in/out  1  upstream W handshake
- s_wdata, s_wstrb, s_wlast  in  DATA_SIZE/DATA_SIZE/8/1  W fields
- m_aw*  out/in(ready)  same as s_aw*  AW toward DBANK
- m_w*  out/in(ready)  same as s_w*  W toward DBANK
- wbuf_idle  out  1  both FIFOs empty and FSM in IDLE; used for power-down gating

## Operation
- AW path: on s_awvalid & s_awready, push all AW fields into the AW FIFO. s_awready = !aw_full.
- W path: on s_wvalid & s_wready, push {wdata, wstrb, wlast} into the W FIFO. s_wready = !w_full. W may arrive before its AW.
- cmpl_cnt, width $clog2(W_DEPTH+1), counts complete bursts held in the W FIFO:
  - +1 on an accepted s_wlast beat.
  - −1 on the m_w handshake with m_wlast.
  - Both in the same cycle: unchanged.
- Output FSM:
  - IDLE: m_awvalid = aw_nonempty & (cmpl_cnt ≠ 0). m_aw* is driven from the AW FIFO head. On m_awvalid & m_awready, pop the AW FIFO and go to DATA.
  - DATA: m_wvalid = 1. m_w* is driven from the W FIFO head (guaranteed non-empty). On m_wvalid & m_wready, pop. If the popped beat has m_wlast, go to IDLE.
- m_wvalid is never asserted in IDLE. m_awvalid is never asserted in DATA.
- m_awvalid and m_wvalid, once asserted, hold with stable payload until the handshake completes.
- Burst-length integrity is the upstream's responsibility: the wlast stored in the FIFO is forwarded unchanged and beats are not counted against awlen.
- With W_DEPTH ≥ max burst length, the pipeline is deadlock-free. A full FIFO always contains at least one complete burst, and draining that burst frees space.

## Timing
- While rst_a is high and in the cycle it is sampled: FIFOs are emptied, cmpl_cnt=0, FSM=IDLE.
- During reset all outputs are 0 (s_awready and s_wready are forced low). wbuf_idle is 1 from the first cycle after reset is released.
- Reset mid-burst discards all buffered AW and W content. No partial burst is emitted afterwards.
- Latency: last W beat accepted at cycle N with its AW already buffered → m_awvalid at N+1.
- If AW is accepted later, at cycle M, m_awvalid is asserted at M+1.
- m_awvalid handshake at cycle K → m_wvalid at K+1. A burst of L beats with m_wready held high completes at K+L.
- After the last-beat handshake at cycle J, the next m_awvalid is asserted at J+1 at the earliest.
- Upstream sustains 1 beat/cycle until a FIFO is full. Ready signals depend only on registered FIFO state; there is no combinational path from m_*ready to s_*ready.

## Structure
- Package nl2_dbank_wr_store_fwd_pkg holds:
  - the AW payload struct typedef (id, addr, size, len, burst, lock, prot, cache);
  - the FSM state enum {IDLE, DATA}.
- Sub-module nl2_dbank_sync_fifo: a parameterised WIDTH/DEPTH synchronous FIFO with registered full/empty and a synchronous active-high clear. It is instantiated twice, once for AW and once for W.

## Test plan
- Single 4-beat burst: AW (id=0, addr=0x100, len=3) precedes W beats 0xA..0xD → m_awvalid asserted the cycle after beat 0xD is accepted; m_w carries 0xA..0xD in order with m_wlast on 0xD; wbuf_idle returns to 1.
- W before AW: 2-beat burst fully accepted, AW arrives 5 cycles later → no m_awvalid until the cycle after the AW is accepted; data is then identical.
- Back-pressure: m_wready low for 10 cycles mid-burst while upstream pushes 16 more beats → s_wready drops once the W FIFO holds 16 entries; no beat is lost or duplicated; order is preserved.
- Simultaneous events: an upstream wlast and a downstream last-beat handshake occur in the same cycle → cmpl_cnt unchanged; the next AW issues the following cycle.
- Max burst: len=15, W_DEPTH=16, plus a second 16-beat burst queued → both forward with no deadlock, 32 beats total.
- Reset mid-burst: rst_a asserted after 3 of 8 beats have been forwarded → outputs go to 0; after release no m_awvalid or m_wvalid appears until a new complete burst is received.
